// File: rtl/jt12_sh_pkg.sv
// Shared types and address helpers for the RAM-based JT12 delay line.
package jt12_sh_pkg;

  typedef enum logic {SH_FLUSH, SH_RUN} sh_state_t;

  // Circular-buffer subtraction: (a - b) mod depth, valid for a < depth, b <= depth.
  function automatic int sh_wrap_sub(input int a, input int b, input int depth);
    return (a >= b) ? a - b : a + depth - b;
  endfunction

  function automatic int sh_clamp(input int sel, input int depth);
    return (sel >= depth) ? depth - 1 : sel;
  endfunction

endpackage

// File: rtl/jt12_sh_mem.sv
// Simple dual-port storage: one sync write, one sync read (drop), one async read (tap).
module jt12_sh_mem #(
  parameter int width = 5,
  parameter int depth = 23,
  parameter int aw    = 5
) (
  input  logic             clk,
  input  logic             we,
  input  logic [aw-1:0]    waddr,
  input  logic [width-1:0] wdata,
  input  logic             re,
  input  logic [aw-1:0]    raddr,
  output logic [width-1:0] rdata,
  input  logic [aw-1:0]    taddr,
  output logic [width-1:0] tdata
);

  logic [width-1:0] mem [depth];

  // Read-before-write on a shared address is what gives the drop its full delay.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

  assign tdata = mem[taddr];

endmodule

// File: rtl/jt12_sh_ram.sv
// Circular-buffer delay line with self-flushing clear and a selectable tap.
//
// state    | meaning
// SH_FLUSH | busy; writes rstval to one slot per clk, cnt walks 0..DEPTH-1
// SH_RUN   | normal shifting on clk_en; clr drops back to SH_FLUSH
module jt12_sh_ram
  import jt12_sh_pkg::*;
#(
  parameter int               width  = 5,
  parameter int               stages = 24,
  parameter logic [width-1:0] rstval = {width{1'b0}},
  localparam int              AW     = $clog2(stages-1)
) (
  input  logic             rst_n,
  input  logic             clk,
  input  logic             clk_en,
  input  logic             clr,
  input  logic [width-1:0] din,
  input  logic [AW-1:0]    tap_sel,
  output logic [width-1:0] drop,
  output logic [width-1:0] tap,
  output logic             busy
);

  localparam int DEPTH = stages - 1;

  sh_state_t        state;
  logic [AW-1:0]    cnt;
  logic [AW-1:0]    wp;
  logic             rd_live;
  logic             accept;
  logic             mem_we;
  logic [AW-1:0]    waddr;
  logic [AW-1:0]    taddr;
  logic [width-1:0] wdata;
  logic [width-1:0] rd_q;
  logic [width-1:0] tdata;

  assign accept = (state == SH_RUN) && clk_en && !clr;

  always_comb begin
    mem_we = 1'b0;
    waddr  = wp;
    wdata  = din;
    if (state == SH_FLUSH) begin
      mem_we = 1'b1;
      waddr  = cnt;
      wdata  = rstval;
    end else if (accept) begin
      mem_we = 1'b1;
    end
  end

  assign taddr = AW'(sh_wrap_sub(int'(wp), sh_clamp(int'(tap_sel), DEPTH) + 1, DEPTH));

  jt12_sh_mem #(
    .width (width),
    .depth (DEPTH),
    .aw    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (waddr),
    .wdata (wdata),
    .re    (accept),
    .raddr (wp),
    .rdata (rd_q),
    .taddr (taddr),
    .tdata (tdata)
  );

  // rd_live masks the unreset RAM read register until a real read has landed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= SH_FLUSH;
      cnt     <= '0;
      wp      <= '0;
      rd_live <= 1'b0;
    end else begin
      case (state)
        SH_FLUSH: begin
          if (cnt == AW'(DEPTH-1)) begin
            cnt   <= '0;
            wp    <= '0;
            state <= SH_RUN;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        SH_RUN: begin
          if (clr) begin
            state   <= SH_FLUSH;
            cnt     <= '0;
            rd_live <= 1'b0;
          end else if (clk_en) begin
            wp      <= (wp == AW'(DEPTH-1)) ? '0 : wp + 1'b1;
            rd_live <= 1'b1;
          end
        end
        default: state <= SH_FLUSH;
      endcase
    end
  end

  assign drop = rd_live ? rd_q : rstval;
  assign tap  = (state == SH_FLUSH) ? rstval : tdata;
  assign busy = (state == SH_FLUSH);

endmodule
